ycr1_dmem_router: RTL and testbench
===================================

YCR1_DMEM_ROUTER -- requirements
Module: ycr1_dmem_router

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 The module SHALL have parameter TMR_ADDR_MASK, default 32'hFFFF_FFE0, the address bits compared for timer select.
REQ-003 The module SHALL have parameter TMR_ADDR_PATTERN, default 32'h0049_0000, the timer window base.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, the response-wait limit in cycles; 0 disables the timeout.
REQ-005 The module SHALL have these ports, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req, core_cmd, core_width[1:0], core_addr[31:0], core_wdata[31:0]  in  core request
- core_req_ack  out  1; core_rdata  out  32; core_resp  out  2  core side
- tmr_req, tmr_cmd, tmr_width[1:0], tmr_addr[31:0], tmr_wdata[31:0]  out  timer-port request
- tmr_req_ack  in  1; tmr_rdata  in  32; tmr_resp  in  2  timer-port return
- ext_*  same widths and directions as tmr_*  default (external) port

Function
REQ-006 Port select SHALL be timer when (core_addr & TMR_ADDR_MASK) == TMR_ADDR_PATTERN, else external.
REQ-007 FSM states SHALL be ADDR (request phase) and DATA (awaiting response); reset state ADDR.
REQ-008 In ADDR, core_req SHALL drive only the selected port's req combinationally; cmd/width/addr/wdata SHALL be broadcast to both ports.
REQ-009 core_req_ack SHALL equal the selected port's req_ack, combinationally.
REQ-010 On core_req & core_req_ack, the router SHALL latch the port select and move to DATA next cycle.
REQ-011 In DATA, core_resp/core_rdata SHALL mirror the latched port's resp/rdata; the other port's return SHALL be ignored.
REQ-012 In DATA, when the latched port's resp != NOTRDY (00), the router SHALL return to ADDR, or stay in DATA with the new latched port if a new request is accepted in that same cycle (back-to-back).
REQ-013 In DATA, a new request SHALL be forwarded only in the cycle the latched port responds; otherwise both port reqs SHALL be 0 and core_req_ack 0.
REQ-014 The wait counter SHALL clear on entry to DATA and increment each DATA cycle without a response.
REQ-015 When the count reaches TIMEOUT (TIMEOUT != 0), core_resp SHALL be RDY_ER (10) with core_rdata 0 for one cycle, and the FSM SHALL return to ADDR.
REQ-016 Attached ports SHALL NOT respond after a timeout; any such late response SHALL NOT be forwarded in ADDR.
REQ-017 Outside DATA, core_resp SHALL be NOTRDY and core_rdata 0.
REQ-018 The router SHALL NOT check width or alignment; the ports do.

Reset
REQ-019 While rst is high, FSM SHALL be ADDR, latched select external, counter 0.
REQ-020 During and after reset, all port reqs and core_req_ack SHALL be 0, and core_resp SHALL be NOTRDY.
REQ-021 Reset mid-transaction SHALL abandon it silently, with no response to the core.

Structure
REQ-022 Response codes (NOTRDY=00, RDY_OK=01, RDY_ER=10) and command codes (RD=0, WR=1) SHALL come from the shared memif package.
REQ-023 The port-select enum (PORT_TMR, PORT_EXT) SHALL be added to the shared memif package.
REQ-024 The FSM state enum and the counter width ($clog2(TIMEOUT+1)) SHALL be local.
REQ-025 No sub-module; one flat module.

Verification
REQ-026 Read 0x0049_0008 with timer acking 1 cycle after req and resp RDY_OK/0x0000_1234 two cycles later -> ext_req stays 0, core sees ack then RDY_OK/0x1234, FSM back to ADDR.
REQ-027 Write 0x8000_0000 data 0xDEAD_BEEF -> only ext_req asserted; tmr_req 0 throughout; ext response forwarded.
REQ-028 Timer read, then external read asserted in the cycle tmr_resp=RDY_OK -> ext_req same cycle, no idle cycle, second response from ext.
REQ-029 TIMEOUT=4, ext acks but never responds -> core_resp=RDY_ER with rdata 0 exactly 4 DATA cycles after accept; next request accepted.
REQ-030 rst pulsed while in DATA -> outputs at reset values the cycle after; a later tmr_resp is not forwarded.
REQ-031 In DATA, tmr_resp=RDY_OK while latched port is ext -> ignored, core_resp NOTRDY.

Source files
------------

// File: rtl/ycr1_memif_pkg.sv
// Shared memory-interface definitions: response codes, command codes and port-select ids.
package ycr1_memif_pkg;

    typedef enum logic [1:0] {
        YCR1_MEM_RESP_NOTRDY = 2'b00,
        YCR1_MEM_RESP_RDY_OK = 2'b01,
        YCR1_MEM_RESP_RDY_ER = 2'b10
    } type_ycr1_mem_resp_e;

    typedef enum logic {
        YCR1_MEM_CMD_RD = 1'b0,
        YCR1_MEM_CMD_WR = 1'b1
    } type_ycr1_mem_cmd_e;

    typedef enum logic {
        PORT_TMR = 1'b0,
        PORT_EXT = 1'b1
    } type_ycr1_port_sel_e;

endpackage

// File: rtl/ycr1_dmem_router.sv
// Routes core data-memory requests to the timer window or the external port.
// Latency: request/ack combinational; response mirrored from the latched port, ER on wait timeout.
// Backpressure: core_req_ack follows the selected port's ack; new requests held off until a response.
module ycr1_dmem_router
    import ycr1_memif_pkg::*;
#(
    parameter logic [31:0] TMR_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [31:0] TMR_ADDR_PATTERN = 32'h0049_0000,
    parameter int unsigned TIMEOUT          = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_cmd,
    input  logic [1:0]  core_width,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_req_ack,
    output logic [31:0] core_rdata,
    output logic [1:0]  core_resp,
    output logic        tmr_req,
    output logic        tmr_cmd,
    output logic [1:0]  tmr_width,
    output logic [31:0] tmr_addr,
    output logic [31:0] tmr_wdata,
    input  logic        tmr_req_ack,
    input  logic [31:0] tmr_rdata,
    input  logic [1:0]  tmr_resp,
    output logic        ext_req,
    output logic        ext_cmd,
    output logic [1:0]  ext_width,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_req_ack,
    input  logic [31:0] ext_rdata,
    input  logic [1:0]  ext_resp
);

    // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e              state, state_next;
    type_ycr1_port_sel_e sel_q, sel_next, sel_new;
    logic [CNT_W-1:0]    cnt_q, cnt_next;

    logic [1:0]  lat_resp;
    logic [31:0] lat_rdata;
    logic        lat_done;
    logic        timeout_hit;
    logic        fwd_en;
    logic        sel_ack;
    logic        accept;

    assign tmr_cmd   = core_cmd;
    assign tmr_width = core_width;
    assign tmr_addr  = core_addr;
    assign tmr_wdata = core_wdata;
    assign ext_cmd   = core_cmd;
    assign ext_width = core_width;
    assign ext_addr  = core_addr;
    assign ext_wdata = core_wdata;

    always_comb begin
        sel_new     = ((core_addr & TMR_ADDR_MASK) == TMR_ADDR_PATTERN) ? PORT_TMR : PORT_EXT;
        lat_resp    = (sel_q == PORT_TMR) ? tmr_resp  : ext_resp;
        lat_rdata   = (sel_q == PORT_TMR) ? tmr_rdata : ext_rdata;
        lat_done    = (state == ST_DATA) && (lat_resp != YCR1_MEM_RESP_NOTRDY);
        timeout_hit = (TIMEOUT != 0) && (state == ST_DATA) && !lat_done && (cnt_q == CNT_MAX);
        // A new request may only overlap the cycle in which the previous one completes.
        fwd_en       = !rst && core_req && ((state == ST_ADDR) || lat_done);
        sel_ack      = (sel_new == PORT_TMR) ? tmr_req_ack : ext_req_ack;
        accept       = fwd_en && sel_ack;
        tmr_req      = fwd_en && (sel_new == PORT_TMR);
        ext_req      = fwd_en && (sel_new == PORT_EXT);
        core_req_ack = accept;
    end

    always_comb begin
        core_resp  = YCR1_MEM_RESP_NOTRDY;
        core_rdata = '0;
        if (!rst && (state == ST_DATA)) begin
            if (timeout_hit) begin
                core_resp  = YCR1_MEM_RESP_RDY_ER;
                core_rdata = '0;
            end else begin
                core_resp  = lat_resp;
                core_rdata = lat_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel_q;
        cnt_next   = cnt_q;
        case (state)
            ST_ADDR: begin
                if (accept) begin
                    state_next = ST_DATA;
                    sel_next   = sel_new;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (lat_done) begin
                    if (accept) begin
                        sel_next = sel_new;
                        cnt_next = '0;
                    end else begin
                        state_next = ST_ADDR;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ADDR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ADDR;
            sel_q <= PORT_EXT;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            sel_q <= sel_next;
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ycr1_dmem_router.sv
// Scripted core/port stimulus with a response scoreboard for ycr1_dmem_router (TIMEOUT=4).
module tb_ycr1_dmem_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_cmd = 1'b0;
    logic [1:0]  core_width = 2'd0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_req_ack;
    logic [31:0] core_rdata;
    logic [1:0]  core_resp;
    logic        tmr_req, tmr_cmd, ext_req, ext_cmd;
    logic [1:0]  tmr_width, ext_width;
    logic [31:0] tmr_addr, tmr_wdata, ext_addr, ext_wdata;
    logic        tmr_req_ack = 1'b0, ext_req_ack = 1'b0;
    logic [31:0] tmr_rdata = '0, ext_rdata = '0;
    logic [1:0]  tmr_resp = 2'b00, ext_resp = 2'b00;

    int total = 0;
    int bad   = 0;
    logic [33:0] sb_q[$];

    always #5 clk = ~clk;

    ycr1_dmem_router #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_cmd(core_cmd), .core_width(core_width),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_req_ack(core_req_ack), .core_rdata(core_rdata), .core_resp(core_resp),
        .tmr_req(tmr_req), .tmr_cmd(tmr_cmd), .tmr_width(tmr_width),
        .tmr_addr(tmr_addr), .tmr_wdata(tmr_wdata),
        .tmr_req_ack(tmr_req_ack), .tmr_rdata(tmr_rdata), .tmr_resp(tmr_resp),
        .ext_req(ext_req), .ext_cmd(ext_cmd), .ext_width(ext_width),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_req_ack(ext_req_ack), .ext_rdata(ext_rdata), .ext_resp(ext_resp)
    );

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every non-NOTRDY response seen by the core must match the oldest expected entry.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!rst && core_resp !== 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {core_resp, core_rdata}, 34'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_resp", {core_resp, core_rdata}, e);
                end
            end
        end
    end

    initial begin
        // Reset with requests and acks active: nothing may leak through.
        core_req = 1'b1; core_addr = 32'h0049_0008; tmr_req_ack = 1'b1; ext_req_ack = 1'b1;
        cyc(); #1;
        chk("rst_tmr_req", tmr_req, 0);
        chk("rst_ext_req", ext_req, 0);
        chk("rst_ack", core_req_ack, 0);
        chk("rst_resp", core_resp, 0);
        cyc(); cyc();
        rst = 1'b0; core_req = 1'b0; tmr_req_ack = 1'b0; ext_req_ack = 1'b0;
        cyc();

        // Timer read, ack one cycle late, response two cycles after ack.
        core_req = 1'b1; core_cmd = 1'b0; core_width = 2'd2; core_addr = 32'h0049_0008;
        #1;
        chk("t1_tmr_req", tmr_req, 1);
        chk("t1_ext_req", ext_req, 0);
        chk("t1_ack_wait", core_req_ack, 0);
        cyc();
        tmr_req_ack = 1'b1; sb_q.push_back({2'b01, 32'h0000_1234});
        #1;
        chk("t1_ack", core_req_ack, 1);
        chk("t1_width_bcast", tmr_width, 2);
        cyc();
        core_req = 1'b0; tmr_req_ack = 1'b0;
        #1;
        chk("t1_wait_resp", core_resp, 0);
        chk("t1_ext_idle", ext_req, 0);
        cyc();
        tmr_resp = 2'b01; tmr_rdata = 32'h0000_1234;
        #1;
        chk("t1_rdata", core_rdata, 32'h0000_1234);
        cyc();
        tmr_resp = 2'b00; tmr_rdata = '0;

        // External write; a stray timer response while waiting is ignored.
        core_req = 1'b1; core_cmd = 1'b1; core_addr = 32'h8000_0000; core_wdata = 32'hDEAD_BEEF;
        ext_req_ack = 1'b1; sb_q.push_back({2'b01, 32'h0000_A5A5});
        #1;
        chk("t2_ext_req", ext_req, 1);
        chk("t2_tmr_req", tmr_req, 0);
        chk("t2_ack", core_req_ack, 1);
        chk("t2_ext_wdata", ext_wdata, 32'hDEAD_BEEF);
        chk("t2_ext_cmd", ext_cmd, 1);
        chk("t2_tmr_addr_bcast", tmr_addr, 32'h8000_0000);
        cyc();
        core_req = 1'b0; ext_req_ack = 1'b0; tmr_resp = 2'b01; tmr_rdata = 32'h0000_0BAD;
        #1;
        chk("t2_other_port_resp", core_resp, 0);
        chk("t2_tmr_req_data", tmr_req, 0);
        cyc();
        tmr_resp = 2'b00; tmr_rdata = '0; ext_resp = 2'b01; ext_rdata = 32'h0000_A5A5;
        #1;
        chk("t2_resp", core_resp, 2'b01);
        cyc();
        ext_resp = 2'b00; ext_rdata = '0;

        // Timer read followed back-to-back by an external read.
        core_req = 1'b1; core_cmd = 1'b0; core_addr = 32'h0049_0010; tmr_req_ack = 1'b1;
        sb_q.push_back({2'b01, 32'h0000_1111});
        #1;
        chk("t3_tmr_req", tmr_req, 1);
        cyc();
        tmr_req_ack = 1'b0; core_addr = 32'h0000_1000; ext_req_ack = 1'b1;
        #1;
        chk("t3_hold_ext_req", ext_req, 0);
        chk("t3_hold_ack", core_req_ack, 0);
        cyc();
        tmr_resp = 2'b01; tmr_rdata = 32'h0000_1111; sb_q.push_back({2'b01, 32'h0000_2222});
        #1;
        chk("t3_b2b_ext_req", ext_req, 1);
        chk("t3_b2b_ack", core_req_ack, 1);
        cyc();
        core_req = 1'b0; ext_req_ack = 1'b0; tmr_resp = 2'b00; tmr_rdata = '0;
        ext_resp = 2'b01; ext_rdata = 32'h0000_2222;
        #1;
        chk("t3_second_rdata", core_rdata, 32'h0000_2222);
        cyc();
        ext_resp = 2'b00; ext_rdata = '0;

        // External read never answered: RDY_ER after four unanswered DATA cycles.
        core_req = 1'b1; core_addr = 32'h0000_2000; ext_req_ack = 1'b1; ext_rdata = 32'hFFFF_FFFF;
        sb_q.push_back({2'b10, 32'h0});
        #1;
        chk("t4_ack", core_req_ack, 1);
        cyc();
        core_req = 1'b0; ext_req_ack = 1'b0;
        #1;
        chk("t4_wait0", core_resp, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(); #1;
            chk("t4_wait", core_resp, 0);
        end
        cyc();
        core_req = 1'b1; ext_req_ack = 1'b1;
        #1;
        chk("t4_err_resp", core_resp, 2'b10);
        chk("t4_err_rdata", core_rdata, 0);
        chk("t4_no_fwd", ext_req, 0);
        cyc();
        ext_rdata = 32'h0000_3333; sb_q.push_back({2'b01, 32'h0000_3333});
        #1;
        chk("t4_next_ack", core_req_ack, 1);
        cyc();
        core_req = 1'b0; ext_req_ack = 1'b0; ext_resp = 2'b01;
        cyc();
        ext_resp = 2'b00; ext_rdata = '0;

        // Reset mid-transaction abandons it; the late timer response is dropped.
        core_req = 1'b1; core_addr = 32'h0049_0004; tmr_req_ack = 1'b1;
        #1;
        chk("t5_ack", core_req_ack, 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("t5_rst_resp", core_resp, 0);
        chk("t5_rst_tmr_req", tmr_req, 0);
        chk("t5_rst_ack", core_req_ack, 0);
        cyc();
        rst = 1'b0; core_req = 1'b0; tmr_req_ack = 1'b0;
        tmr_resp = 2'b01; tmr_rdata = 32'h0000_5555;
        #1;
        chk("t5_late_resp", core_resp, 0);
        chk("t5_late_rdata", core_rdata, 0);
        cyc();
        tmr_resp = 2'b00; tmr_rdata = '0;
        cyc(); cyc();

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
